// File: rtl/fetch_unit_if.sv
// fetch_unit_if: redirect, imem request/response and decode-side handshakes.
// master = fetch_unit side, slave = memory/decode environment side.
interface fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_ready;

  modport master (
    input  redirect_valid, redirect_pc,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    input  inst_ready,
    output imem_req_valid, imem_req_addr,
    output inst_valid, inst_pc, inst_data
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    output inst_ready,
    input  imem_req_valid, imem_req_addr,
    input  inst_valid, inst_pc, inst_data
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding imem fetcher feeding a 2-entry inst queue.
// Ports: clk, rst (sync, active-high), bus (fetch_unit_if.master).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_req_pc;
  logic [31:0] r_q_pc   [2];
  logic [31:0] r_q_data [2];
  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_count;

  logic        w_redir;
  logic [31:0] w_redir_pc;
  logic        w_hs;
  logic        w_resp;
  logic        w_push;
  logic        w_pop;
  logic        w_inst_valid;

  assign w_redir    = bus.redirect_valid;
  assign w_redir_pc = bus.redirect_pc & 32'hFFFF_FFFC;
  assign w_resp     = bus.imem_resp_valid;

  // Outputs are forced low while rst is held.
  assign bus.imem_req_valid = !rst &&
                              (r_state == S_REQ) &&
                              (r_count != 2'd2);
  assign bus.imem_req_addr  = r_fetch_pc;

  assign w_inst_valid   = !rst && (r_count != 2'd0);
  assign bus.inst_valid = w_inst_valid;
  assign bus.inst_pc    = w_inst_valid ? r_q_pc[r_rptr]   : 32'h0;
  assign bus.inst_data  = w_inst_valid ? r_q_data[r_rptr] : 32'h0;

  assign w_hs   = bus.imem_req_valid & bus.imem_req_ready;
  // A redirect kills both the arriving response and the head pop.
  assign w_push = (r_state == S_WAIT) && w_resp && !w_redir;
  assign w_pop  = w_inst_valid && bus.inst_ready && !w_redir;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= 32'h0;
      r_count    <= 2'd0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
    end else begin
      if (w_hs)
        r_req_pc <= r_fetch_pc;

      if (w_redir)
        r_fetch_pc <= w_redir_pc;
      else if (w_hs)
        r_fetch_pc <= r_fetch_pc + 32'd4;

      if (w_redir) begin
        r_count <= 2'd0;
        r_wptr  <= 1'b0;
        r_rptr  <= 1'b0;
      end else begin
        if (w_push) begin
          r_q_pc[r_wptr]   <= r_req_pc;
          r_q_data[r_wptr] <= bus.imem_resp_data;
          r_wptr           <= ~r_wptr;
        end
        if (w_pop)
          r_rptr <= ~r_rptr;
        unique case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end

      unique case (r_state)
        S_REQ:
          if (w_hs)
            r_state <= w_redir ? S_DROP : S_WAIT;
        S_WAIT:
          if (w_resp)
            r_state <= S_REQ;
          else if (w_redir)
            r_state <= S_DROP;
        S_DROP:
          if (w_resp)
            r_state <= S_REQ;
        default:
          r_state <= S_REQ;
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h00000000, the first fetch address after reset.
REQ-002 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, synchronous, active-high reset.
REQ-004 Port redirect_valid, input, 1, a taken branch or jump replaces the fetch PC this cycle.
REQ-005 Port redirect_pc, input, 32, the new fetch address; bits [1:0] are ignored and treated as 0.
REQ-006 Port imem_req_valid, output, 1, a fetch request is presented to instruction memory.
REQ-007 Port imem_req_addr, output, 32, the word-aligned fetch address.
REQ-008 Port imem_req_ready, input, 1, memory accepts the request; handshake = valid & ready.
REQ-009 Port imem_resp_valid, input, 1, the instruction word for the oldest accepted request is present.
REQ-010 Port imem_resp_data, input, 32, the instruction word.
REQ-011 Port inst_valid, output, 1, the queue head holds an instruction for decode.
REQ-012 Port inst_pc, output, 32, the address of the head instruction.
REQ-013 Port inst_data, output, 32, the head instruction word.
REQ-014 Port inst_ready, input, 1, decode consumes the head; pop = inst_valid & inst_ready.

Function
REQ-015 The fetch_pc register SHALL advance by 4 on each request handshake, wrapping from 32'hFFFFFFFC to 32'h00000000.
REQ-016 The FSM SHALL have three states: REQ (may issue), WAIT (one request outstanding), DROP (outstanding response is stale).
REQ-017 At most one request SHALL be outstanding; no request is issued in WAIT or DROP.
REQ-018 In REQ, imem_req_valid = (count < 2), where count is the 2-entry queue occupancy, and imem_req_addr = fetch_pc.
REQ-019 On a handshake in REQ, the FSM SHALL move REQ->WAIT; otherwise it stays in REQ.
REQ-020 In WAIT, on imem_resp_valid the FSM SHALL push {pc of request, imem_resp_data} into the queue and return to REQ.
REQ-021 In DROP, on imem_resp_valid the FSM SHALL discard the response and move to REQ.
REQ-022 A pushed instruction SHALL appear at inst_* on the next cycle, giving 1-cycle response-to-inst_valid latency. Queue order is FIFO.
REQ-023 A push and a pop in the same cycle SHALL both take effect, leaving count unchanged. Pop when empty, and push when full, cannot occur by construction.
REQ-024 On redirect_valid, all of the following SHALL happen:
- queue flushed (count=0);
- the same-cycle pop is ignored;
- fetch_pc = {redirect_pc[31:2],2'b00} on the next cycle.
REQ-025 The redirect state move SHALL be:
- REQ without handshake -> REQ;
- REQ with handshake -> DROP;
- WAIT without response -> DROP;
- WAIT with response -> REQ, response discarded;
- DROP without response -> DROP;
- DROP with response -> REQ.
REQ-026 imem_req_addr MAY change while imem_req_valid is high only as a result of a redirect.
REQ-027 inst_valid SHALL equal (count != 0), with no combinational path from inst_ready to inst_valid.

Reset
REQ-028 While rst is high on a rising edge, the following SHALL hold:
- state = REQ;
- fetch_pc = RESET_PC;
- count = 0;
- queue pointers = 0.
REQ-029 During reset, imem_req_valid and inst_valid SHALL be 0. inst_pc and inst_data SHALL be 0.
REQ-030 The first request SHALL be presented in the first cycle after rst deasserts.
REQ-031 Reset during WAIT or DROP SHALL abandon the outstanding request. A response arriving after reset is ignored unless a new request has been accepted.

Verification
REQ-032 Streaming:
- stimulus: ready always 1, memory responds next cycle with data = addr ^ 32'hA5A5A5A5;
- required response: inst_pc sequence 0,4,8,C with matching data, and one request per 2 cycles.
REQ-033 Backpressure:
- stimulus: inst_ready = 0;
- required response: exactly 2 instructions queued (pc 0,4), imem_req_valid stays 0;
- then raise inst_ready for 1 cycle: one pop and a new request for addr 8.
REQ-034 Redirect in WAIT:
- stimulus: redirect_pc = 32'h00000103;
- required response: the in-flight response is dropped, the next request address is 32'h00000100, and the first inst_pc after the redirect is 32'h00000100.
REQ-035 Redirect coincident with response and pop:
- required response: queue empty next cycle, no push, state REQ, fetch_pc = redirect target.
REQ-036 Wrap:
- stimulus: redirect to 32'hFFFFFFFC;
- required response: the next two inst_pc are FFFFFFFC then 00000000.
REQ-037 Reset mid-WAIT:
- stimulus: assert rst for 1 cycle while a request is outstanding;
- required response: outputs are 0 during reset, the first request after reset is at RESET_PC, and a late stale response is not enqueued.
